axi_lite_vram_port: RTL

//  Parametrised AXI4-Lite slave front-end for the text/graphics display IP.

---
 rtl/axi_lite_vram_port_pkg.sv | 28 ++
 rtl/axi_lite_vram_port_bram.sv | 55 +++++
 rtl/axi_lite_vram_port.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_vram_port_pkg.sv
// Shared AXI response codes, FSM state types and the address decoder for the
// VRAM/control-register AXI4-Lite port.
package axi_vram_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_VALID} rd_state_t;

    typedef struct packed {
        logic        is_vram;
        logic        is_ctrl;
        logic [31:0] index;
    } decode_t;

    // Control registers sit directly above VRAM; their index is rebased to 0.
    function automatic decode_t decode(input logic [31:0] word_idx,
                                       input logic [31:0] vram_words,
                                       input logic [31:0] num_ctrl);
        decode_t d;
        d.is_vram = (word_idx < vram_words);
        d.is_ctrl = !d.is_vram && (word_idx < vram_words + num_ctrl);
        d.index   = d.is_ctrl ? (word_idx - vram_words) : word_idx;
        return d;
    endfunction

endpackage

// File: rtl/axi_lite_vram_port_bram.sv
// True dual-port VRAM: port A read/byte-write (read-first), port B read-only.
// Both read paths share the same LAT-cycle output pipeline depth.
module vram_dp_bram #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 1200,
    parameter int  LAT    = 2,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int NB     = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_a_en,
    input  logic [NB-1:0]     i_a_be,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic [DATA_W-1:0] o_a_rdata,
    output logic              o_a_rvalid,
    input  logic [ADDR_W-1:0] i_b_addr,
    output logic [DATA_W-1:0] o_b_rdata
);

    logic [DATA_W-1:0] r_mem    [DEPTH];
    logic [DATA_W-1:0] r_a_pipe [LAT];
    logic [DATA_W-1:0] r_b_pipe [LAT];
    logic [LAT:1]      r_vld_pipe;

    // Reads sample the array before this edge's write lands, giving read-first.
    always_ff @(posedge i_clk) begin
        if (i_a_en)
            r_a_pipe[0] <= r_mem[i_a_addr];
        r_b_pipe[0] <= r_mem[i_b_addr];
        for (int b = 0; b < NB; b++)
            if (i_a_be[b])
                r_mem[i_a_addr][b*8 +: 8] <= i_a_wdata[b*8 +: 8];
        for (int s = 1; s < LAT; s++) begin
            r_a_pipe[s] <= r_a_pipe[s-1];
            r_b_pipe[s] <= r_b_pipe[s-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[1] <= i_a_en;
            for (int s = 2; s <= LAT; s++)
                r_vld_pipe[s] <= r_vld_pipe[s-1];
        end
    end

    assign o_a_rdata  = r_a_pipe[LAT-1];
    assign o_a_rvalid = r_vld_pipe[LAT];
    assign o_b_rdata  = r_b_pipe[LAT-1];

endmodule

// File: rtl/axi_lite_vram_port.sv
// AXI4-Lite slave mapping a dual-port VRAM plus control/palette registers,
// with a free-running read-only video port into the same VRAM.
module axi_lite_vram_port
    import axi_vram_pkg::*;
#(
    parameter int  C_AXI_DATA_WIDTH = 32,
    parameter int  C_AXI_ADDR_WIDTH = 16,
    parameter int  VRAM_WORDS       = 1200,
    parameter int  NUM_CTRL_REGS    = 8,
    parameter int  RD_LATENCY       = 2,
    localparam int DW               = C_AXI_DATA_WIDTH,
    localparam int NB               = DW / 8,
    localparam int VAW              = $clog2(VRAM_WORDS)
) (
    input  logic                          axi_aclk,
    input  logic                          axi_areset,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [2:0]                    axi_awprot,
    input  logic                          axi_awvalid,
    output logic                          axi_awready,
    input  logic [DW-1:0]                 axi_wdata,
    input  logic [NB-1:0]                 axi_wstrb,
    input  logic                          axi_wvalid,
    output logic                          axi_wready,
    output logic [1:0]                    axi_bresp,
    output logic                          axi_bvalid,
    input  logic                          axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [2:0]                    axi_arprot,
    input  logic                          axi_arvalid,
    output logic                          axi_arready,
    output logic [DW-1:0]                 axi_rdata,
    output logic [1:0]                    axi_rresp,
    output logic                          axi_rvalid,
    input  logic                          axi_rready,
    input  logic [VAW-1:0]                vid_addr,
    output logic [DW-1:0]                 vid_data,
    output logic [NUM_CTRL_REGS*DW-1:0]   ctrl_regs
);

    localparam int ADDR_LSB = $clog2(NB);

    wr_state_t                     r_wr_state;
    logic                          r_aw_held, r_w_held;
    logic [C_AXI_ADDR_WIDTH-1:0]   r_awaddr;
    logic [DW-1:0]                 r_wdata;
    logic [NB-1:0]                 r_wstrb;
    logic [1:0]                    r_bresp;
    logic [DW-1:0]                 r_ctrl [NUM_CTRL_REGS];

    rd_state_t                     r_rd_state;
    logic [C_AXI_ADDR_WIDTH-1:0]   r_araddr;
    logic                          r_rd_issued;
    logic [DW-1:0]                 r_rdata;
    logic [1:0]                    r_rresp;

    decode_t                       w_wdec, w_rdec;
    logic                          w_aw_hs, w_w_hs, w_ar_hs;
    logic                          w_commit, w_commit_vram, w_rd_issue;
    logic [VAW-1:0]                w_a_addr;
    logic [NB-1:0]                 w_a_be;
    logic [DW-1:0]                 w_a_rdata, w_ctrl_rd;
    logic                          w_a_rvalid;
    logic                          w_unused;

    assign w_wdec = decode(32'(r_awaddr) >> ADDR_LSB, 32'(VRAM_WORDS), 32'(NUM_CTRL_REGS));
    assign w_rdec = decode(32'(r_araddr) >> ADDR_LSB, 32'(VRAM_WORDS), 32'(NUM_CTRL_REGS));

    assign axi_awready = !axi_areset && (r_wr_state == W_COLLECT) && !r_aw_held;
    assign axi_wready  = !axi_areset && (r_wr_state == W_COLLECT) && !r_w_held;
    assign axi_arready = !axi_areset && (r_rd_state == R_IDLE);
    assign axi_bvalid  = (r_wr_state == W_RESP);
    assign axi_rvalid  = (r_rd_state == R_VALID);
    assign axi_bresp   = r_bresp;
    assign axi_rresp   = r_rresp;
    assign axi_rdata   = r_rdata;

    assign w_aw_hs = axi_awvalid && axi_awready;
    assign w_w_hs  = axi_wvalid && axi_wready;
    assign w_ar_hs = axi_arvalid && axi_arready;

    assign w_commit      = (r_wr_state == W_COMMIT);
    assign w_commit_vram = w_commit && w_wdec.is_vram;

    // Port A is shared: a read may only issue alongside a commit to the same
    // word (read-first returns the old data); otherwise it waits a cycle.
    assign w_rd_issue = (r_rd_state == R_WAIT) && !r_rd_issued && w_rdec.is_vram &&
                        (!w_commit_vram || (w_wdec.index == w_rdec.index));
    assign w_a_addr   = w_commit_vram ? w_wdec.index[VAW-1:0] : w_rdec.index[VAW-1:0];
    assign w_a_be     = w_commit_vram ? r_wstrb : '0;

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_wr_state <= W_COLLECT;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= AXI_RESP_OKAY;
        end else begin
            case (r_wr_state)
                W_COLLECT: begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= axi_awaddr;
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= axi_wdata;
                        r_wstrb  <= axi_wstrb;
                    end
                    if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs))
                        r_wr_state <= W_COMMIT;
                end
                W_COMMIT: begin
                    r_bresp    <= (w_wdec.is_vram || w_wdec.is_ctrl) ? AXI_RESP_OKAY
                                                                     : AXI_RESP_SLVERR;
                    r_wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (axi_bready) begin
                        r_wr_state <= W_COLLECT;
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                    end
                end
                default: r_wr_state <= W_COLLECT;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            for (int r = 0; r < NUM_CTRL_REGS; r++)
                r_ctrl[r] <= '0;
        end else if (w_commit && w_wdec.is_ctrl) begin
            for (int r = 0; r < NUM_CTRL_REGS; r++)
                if (w_wdec.index == 32'(r))
                    for (int b = 0; b < NB; b++)
                        if (r_wstrb[b])
                            r_ctrl[r][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
    end

    always_comb begin
        w_ctrl_rd = '0;
        for (int r = 0; r < NUM_CTRL_REGS; r++)
            if (w_rdec.is_ctrl && (w_rdec.index == 32'(r)))
                w_ctrl_rd = r_ctrl[r];
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_rd_state  <= R_IDLE;
            r_araddr    <= '0;
            r_rd_issued <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= AXI_RESP_OKAY;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_araddr    <= axi_araddr;
                        r_rd_issued <= 1'b0;
                        r_rd_state  <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (w_rd_issue)
                        r_rd_issued <= 1'b1;
                    if (w_rdec.is_vram) begin
                        if (w_a_rvalid) begin
                            r_rdata    <= w_a_rdata;
                            r_rresp    <= AXI_RESP_OKAY;
                            r_rd_state <= R_VALID;
                        end
                    end else begin
                        r_rdata    <= w_ctrl_rd;
                        r_rresp    <= w_rdec.is_ctrl ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                        r_rd_state <= R_VALID;
                    end
                end
                R_VALID: begin
                    if (axi_rready)
                        r_rd_state <= R_IDLE;
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    vram_dp_bram #(
        .DATA_W (DW),
        .DEPTH  (VRAM_WORDS),
        .LAT    (RD_LATENCY)
    ) u_bram (
        .i_clk      (axi_aclk),
        .i_rst      (axi_areset),
        .i_a_en     (w_rd_issue),
        .i_a_be     (w_a_be),
        .i_a_addr   (w_a_addr),
        .i_a_wdata  (r_wdata),
        .o_a_rdata  (w_a_rdata),
        .o_a_rvalid (w_a_rvalid),
        .i_b_addr   (vid_addr),
        .o_b_rdata  (vid_data)
    );

    for (genvar g = 0; g < NUM_CTRL_REGS; g++) begin : g_ctrl_out
        assign ctrl_regs[g*DW +: DW] = r_ctrl[g];
    end

    assign w_unused = ^{axi_awprot, axi_arprot};

endmodule
